// File: rtl/euclid_pkg.sv
// Shared definitions for the Euclidean key-equation sequencer: state encoding,
// datapath mux select codes and CONTROL word layout.
package euclid_pkg;

  localparam int unsigned CTRL_W    = 5;
  localparam int unsigned CTL_RUN   = 4;
  localparam int unsigned CTL_A_LSB = 2;
  localparam int unsigned CTL_B_LSB = 0;
  localparam int unsigned SEL_W     = 2;

  // Mux select codes; on the B side SEL_LOAD (01) means "copy A".
  localparam logic [SEL_W-1:0] SEL_FDBK = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LOAD = 2'b01;
  localparam logic [SEL_W-1:0] SEL_ALT  = 2'b10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_SWAP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DIV  = ST_DIV,
    SWAP = ST_SWAP,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } state_e;

  // Moore CONTROL word for a given state.
  function automatic logic [CTRL_W-1:0] ctrl_for(input state_e s);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTL_A_LSB +: SEL_W] = SEL_ALT;
    c[CTL_B_LSB +: SEL_W] = SEL_ALT;
    case (s)
      LOAD: begin
        c[CTL_RUN]            = 1'b1;
        c[CTL_A_LSB +: SEL_W] = SEL_LOAD;
      end
      DIV: begin
        c[CTL_RUN]            = 1'b1;
        c[CTL_A_LSB +: SEL_W] = SEL_FDBK;
        c[CTL_B_LSB +: SEL_W] = SEL_FDBK;
      end
      SWAP: begin
        c[CTL_RUN]            = 1'b1;
        c[CTL_B_LSB +: SEL_W] = SEL_LOAD;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/euclid_ctrl_cnt.sv
// Clear/enable up-counter with a terminal-count flag at LIMIT-1.
module euclid_ctrl_cnt #(
  parameter int unsigned W     = 2,
  parameter int unsigned LIMIT = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority over count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/euclid_ctrl_fsm.sv
// Sequencer for the RS(15,11) Euclidean division datapath: load, divide,
// swap, terminate, with a one-cycle done pulse.
// Optional watchdog abort enabled by defining EUCLID_CTRL_WDOG_EN.
module euclid_ctrl_fsm
  import euclid_pkg::*;
#(
  parameter int unsigned MAX_ITER    = 2,
  parameter int unsigned DIV_CYCLES  = 2,
  parameter int unsigned WDOG_CYCLES = 31
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              deg_done,
  output logic [CTRL_W-1:0] CONTROL,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        iter_cnt
);

  localparam int unsigned DIV_W  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int unsigned WDOG_W = 5;

  // Reject configurations the counters cannot represent.
  if (MAX_ITER < 1 || MAX_ITER > 3 || DIV_CYCLES < 1 ||
      WDOG_CYCLES < 2 || WDOG_CYCLES > 31) begin : g_bad_cfg
    $error("euclid_ctrl_fsm: unsupported parameter set");
  end

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        iter_q, iter_d;
  logic              deg_seen_q, deg_seen_d;
  logic              start_q;
  logic              start_rise_c;
  logic [2:0]        iter_next_c;
  logic              div_tc_c;
  logic              wdog_trip_c;

  // A start held high across a run must drop and rise again to be accepted.
  assign start_rise_c = start & ~start_q;
  assign iter_next_c  = {1'b0, iter_q} + 3'd1;

  // Division step counter: runs only in DIV, wraps at the last feedback cycle.
  euclid_ctrl_cnt #(
    .W     (DIV_W),
    .LIMIT (DIV_CYCLES)
  ) u_div_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   ((state_q != DIV) || div_tc_c),
    .en    (state_q == DIV),
    .tc_c  (div_tc_c)
  );

`ifdef EUCLID_CTRL_WDOG_EN
  logic wdog_tc_c;
  logic fail_q;

  // Watchdog: zero in LOAD, so ERR lands on the WDOG_CYCLES-th busy cycle.
  euclid_ctrl_cnt #(
    .W     (WDOG_W),
    .LIMIT (WDOG_CYCLES - 1)
  ) u_wdog_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tc_c  (wdog_tc_c)
  );

  assign wdog_trip_c = wdog_tc_c &&
                       ((state_q == LOAD) || (state_q == DIV) || (state_q == SWAP));

  // Registered one-cycle abort pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= (state_d == ERR);
    end
  end

  assign fail = fail_q;
`else
  assign wdog_trip_c = 1'b0;
  assign fail        = 1'b0;
`endif

  // Next-state, iteration bookkeeping and Moore outputs from the next state.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    deg_seen_d = deg_seen_q;

    if (state_q != IDLE && deg_done) begin
      deg_seen_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        iter_d     = 2'd0;
        deg_seen_d = 1'b0;
        if (start_rise_c) begin
          state_d = LOAD;
        end
      end
      LOAD: state_d = DIV;
      DIV: begin
        if (div_tc_c) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        if (iter_q != 2'd3) begin
          iter_d = iter_next_c[1:0];
        end
        if (deg_seen_q || deg_done || (iter_next_c == 3'(MAX_ITER))) begin
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog overrides any same-cycle termination decision.
    if (wdog_trip_c) begin
      state_d = ERR;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    control_d = ctrl_for(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      control_q  <= ctrl_for(IDLE);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_q     <= 2'd0;
      deg_seen_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      control_q  <= control_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      iter_q     <= iter_d;
      deg_seen_q <= deg_seen_d;
      start_q    <= start;
    end
  end

  assign CONTROL  = control_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign iter_cnt = iter_q;

endmodule
